// File: rtl/hex_display_driver.sv
// ---------------------------------------------------------------------------
// hex_display_driver
//
// Purpose:
//   Converts a 64-bit unsigned register value into four 7-segment digits
//   (thousands..units) with a sequential double-dabble converter. Values
//   above 9999 show dashes on all four displays and raise ovf.
//
// Timing:
//   A load accepted at edge N starts the conversion. Edges N+1..N+14 each
//   perform one double-dabble step. At edge N+15 the displays and ovf are
//   updated, done pulses for one cycle and busy drops. load is ignored
//   while busy is high, including the DONE cycle.
//
// Ports:
//   clk              in   1   clock, rising edge
//   rst              in   1   synchronous active-high reset
//   value            in   64  value to display, sampled on an accepted load
//   load             in   1   conversion request, accepted while busy=0
//   busy             out  1   conversion in progress
//   done             out  1   one-cycle pulse when the displays update
//   ovf              out  1   last accepted value exceeded 9999
//   HEX3..HEX0       out  7   active-low segments {g,f,e,d,c,b,a}
//
// Configuration macro:
//   HEX_LEADING_ZERO_BLANK_EN  when defined, leading zero digits on
//                              HEX3..HEX1 are blanked; HEX0 always shows.
// ---------------------------------------------------------------------------
module hex_display_driver (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] value,
  input  logic        load,
  output logic        busy,
  output logic        done,
  output logic        ovf,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX0
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Index of the last double-dabble step (14 steps for a 14-bit operand).
  localparam logic [3:0] LAST_STEP = 4'd13;

  logic [1:0]  r_state;
  logic [13:0] r_bin;
  logic [15:0] r_bcd;
  logic [3:0]  r_count;
  logic        r_ovfLatch;
  logic        r_busy;
  logic        r_done;
  logic        r_ovf;
  logic [6:0]  r_hex3;
  logic [6:0]  r_hex2;
  logic [6:0]  r_hex1;
  logic [6:0]  r_hex0;

  logic [15:0] w_bcdAdj;
  logic [29:0] w_shift;
  logic [6:0]  w_hex3;
  logic [6:0]  w_hex2;
  logic [6:0]  w_hex1;
  logic [6:0]  w_hex0;

  function automatic logic [6:0] segEncode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  function automatic logic [3:0] addThree(input logic [3:0] digit);
    return (digit >= 4'd5) ? (digit + 4'd3) : digit;
  endfunction

  // Double-dabble step: correct each BCD digit, then shift {bcd,bin} left.
  // Only 14 binary bits are converted; values that need a fifth digit are
  // overflow cases and show dashes, so losing the top BCD bit is harmless.
  assign w_bcdAdj = {addThree(r_bcd[15:12]), addThree(r_bcd[11:8]),
                     addThree(r_bcd[7:4]),   addThree(r_bcd[3:0])};
  assign w_shift  = {w_bcdAdj, r_bin} << 1;

  // Segment patterns for the finished conversion, with optional leading
  // zero blanking; overflow overrides everything with dashes.
  always_comb begin
    w_hex3 = segEncode(r_bcd[15:12]);
    w_hex2 = segEncode(r_bcd[11:8]);
    w_hex1 = segEncode(r_bcd[7:4]);
    w_hex0 = segEncode(r_bcd[3:0]);
`ifdef HEX_LEADING_ZERO_BLANK_EN
    if (r_bcd[15:12] == 4'd0) begin
      w_hex3 = SEG_BLANK;
    end
    if (r_bcd[15:8] == 8'd0) begin
      w_hex2 = SEG_BLANK;
    end
    if (r_bcd[15:4] == 12'd0) begin
      w_hex1 = SEG_BLANK;
    end
`else
`endif
    if (r_ovfLatch) begin
      w_hex3 = SEG_DASH;
      w_hex2 = SEG_DASH;
      w_hex1 = SEG_DASH;
      w_hex0 = SEG_DASH;
    end
  end

  // Control FSM and datapath. done defaults low so it only pulses in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_bin      <= '0;
      r_bcd      <= '0;
      r_count    <= '0;
      r_ovfLatch <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      r_hex3     <= SEG_BLANK;
      r_hex2     <= SEG_BLANK;
      r_hex1     <= SEG_BLANK;
      r_hex0     <= SEG_BLANK;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (load) begin
            r_bin      <= value[13:0];
            r_bcd      <= '0;
            r_count    <= '0;
            r_ovfLatch <= (value > 64'd9999);
            r_busy     <= 1'b1;
            r_state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_bcd   <= w_shift[29:14];
          r_bin   <= w_shift[13:0];
          r_count <= r_count + 4'd1;
          if (r_count == LAST_STEP) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_hex3  <= w_hex3;
          r_hex2  <= w_hex2;
          r_hex1  <= w_hex1;
          r_hex0  <= w_hex0;
          r_ovf   <= r_ovfLatch;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign ovf  = r_ovf;
  assign HEX3 = r_hex3;
  assign HEX2 = r_hex2;
  assign HEX1 = r_hex1;
  assign HEX0 = r_hex0;

endmodule

// File: tb/tb_hex_display_driver.sv
// ---------------------------------------------------------------------------
// tb_hex_display_driver
//
// Directed testbench for hex_display_driver. Drives inputs on the falling
// edge, samples outputs 1 ns after each rising edge, and compares against
// hand-computed segment patterns, latencies and pulse counts.
// ---------------------------------------------------------------------------
module tb_hex_display_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [63:0] value;
  logic        busy;
  logic        done;
  logic        ovf;
  logic [6:0]  HEX3;
  logic [6:0]  HEX2;
  logic [6:0]  HEX1;
  logic [6:0]  HEX0;

  int errors = 0;
  int checks = 0;

  hex_display_driver dut (
    .clk   (clk),
    .rst   (rst),
    .value (value),
    .load  (load),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf),
    .HEX3  (HEX3),
    .HEX2  (HEX2),
    .HEX1  (HEX1),
    .HEX0  (HEX0)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Drive inputs on the falling edge, let one rising edge pass, then settle.
  task automatic applyStimulus(input logic [63:0] v, input logic ld,
                               input logic rs);
    @(negedge clk);
    value = v;
    load  = ld;
    rst   = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic checkDisplay(input string tag, input logic [6:0] e3,
                              input logic [6:0] e2, input logic [6:0] e1,
                              input logic [6:0] e0, input logic eOvf);
    checkOutput({tag, "_hex3"}, 64'(HEX3), 64'(e3));
    checkOutput({tag, "_hex2"}, 64'(HEX2), 64'(e2));
    checkOutput({tag, "_hex1"}, 64'(HEX1), 64'(e1));
    checkOutput({tag, "_hex0"}, 64'(HEX0), 64'(e0));
    checkOutput({tag, "_ovf"},  64'(ovf),  64'(eOvf));
  endtask

  // One load pulse, then 20 edges of observation: done must appear exactly
  // once, 15 edges after the load edge, with busy high for 15 samples.
  task automatic runConversion(input string tag, input logic [63:0] v,
                               input logic [6:0] e3, input logic [6:0] e2,
                               input logic [6:0] e1, input logic [6:0] e0,
                               input logic eOvf);
    int doneEdge;
    int doneCount;
    int busyCount;
    doneEdge  = 0;
    doneCount = 0;
    busyCount = 0;
    applyStimulus(v, 1'b1, 1'b0);
    if (busy) busyCount++;
    for (int e = 1; e <= 20; e++) begin
      applyStimulus(v, 1'b0, 1'b0);
      if (busy) busyCount++;
      if (done) begin
        doneCount++;
        if (doneEdge == 0) doneEdge = e;
      end
    end
    checkOutput({tag, "_latency"}, 64'(doneEdge), 64'd15);
    checkOutput({tag, "_doneCount"}, 64'(doneCount), 64'd1);
    checkOutput({tag, "_busyCycles"}, 64'(busyCount), 64'd15);
    checkDisplay(tag, e3, e2, e1, e0, eOvf);
  endtask

  initial begin
    int doneEdge;
    int doneCount;
    int d1;
    int d2;
    int d3;

    value = '0;
    load  = 1'b0;
    rst   = 1'b1;

    // Reset, then idle with no load.
    applyStimulus(64'd0, 1'b0, 1'b1);
    applyStimulus(64'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(64'd0, 1'b0, 1'b0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkDisplay("reset", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 1'b0);

    // Plain conversions.
    runConversion("v1597", 64'd1597, 7'h79, 7'h12, 7'h10, 7'h78, 1'b0);
`ifdef HEX_LEADING_ZERO_BLANK_EN
    runConversion("v7", 64'd7, 7'h7F, 7'h7F, 7'h7F, 7'h78, 1'b0);
    runConversion("v0", 64'd0, 7'h7F, 7'h7F, 7'h7F, 7'h40, 1'b0);
`else
    runConversion("v7", 64'd7, 7'h40, 7'h40, 7'h40, 7'h78, 1'b0);
    runConversion("v0", 64'd0, 7'h40, 7'h40, 7'h40, 7'h40, 1'b0);
`endif
    runConversion("v10000", 64'd10000, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 1'b1);
    runConversion("vBit63", 64'h8000_0000_0000_0000,
                  7'h3F, 7'h3F, 7'h3F, 7'h3F, 1'b1);
    runConversion("v9999", 64'd9999, 7'h10, 7'h10, 7'h10, 7'h10, 1'b0);

    // Loads at N+5 and N+15 must be ignored.
    doneEdge  = 0;
    doneCount = 0;
    for (int e = 1; e <= 26; e++) begin
      if (e == 1)
        applyStimulus(64'd42, 1'b1, 1'b0);
      else if (e == 6 || e == 16)
        applyStimulus(64'd8888, 1'b1, 1'b0);
      else
        applyStimulus(64'd42, 1'b0, 1'b0);
      if (done) begin
        doneCount++;
        if (doneEdge == 0) doneEdge = e;
      end
    end
    checkOutput("ignore_doneEdge", 64'(doneEdge), 64'd16);
    checkOutput("ignore_doneCount", 64'(doneCount), 64'd1);
    checkOutput("ignore_busyAfter", 64'(busy), 64'd0);
`ifdef HEX_LEADING_ZERO_BLANK_EN
    checkDisplay("ignore", 7'h7F, 7'h7F, 7'h19, 7'h24, 1'b0);
`else
    checkDisplay("ignore", 7'h40, 7'h40, 7'h19, 7'h24, 1'b0);
`endif

    // Load held high: back-to-back conversions every 16 cycles.
    d1 = 0;
    d2 = 0;
    d3 = 0;
    doneCount = 0;
    for (int e = 1; e <= 48; e++) begin
      applyStimulus(64'd1597, (e <= 47), 1'b0);
      if (done) begin
        doneCount++;
        if (d1 == 0) d1 = e;
        else if (d2 == 0) d2 = e;
        else if (d3 == 0) d3 = e;
      end
    end
    for (int i = 0; i < 3; i++) applyStimulus(64'd0, 1'b0, 1'b0);
    checkOutput("held_firstDone", 64'(d1), 64'd16);
    checkOutput("held_period1", 64'(d2 - d1), 64'd16);
    checkOutput("held_period2", 64'(d3 - d2), 64'd16);
    checkOutput("held_doneCount", 64'(doneCount), 64'd3);
    checkOutput("held_busyAfter", 64'(busy), 64'd0);

    // Reset at N+7 aborts the conversion, with a load present during reset.
    runConversion("preAbort", 64'd10000, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 1'b1);
    doneCount = 0;
    applyStimulus(64'd2024, 1'b1, 1'b0);
    for (int e = 1; e <= 6; e++) applyStimulus(64'd2024, 1'b0, 1'b0);
    applyStimulus(64'd5555, 1'b1, 1'b1);
    if (done) doneCount++;
    for (int e = 1; e <= 20; e++) begin
      applyStimulus(64'd5555, 1'b0, 1'b0);
      if (done) doneCount++;
    end
    checkOutput("abort_doneCount", 64'(doneCount), 64'd0);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkDisplay("abort", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 1'b0);

    // Next conversion after the abort works normally.
    runConversion("v2024", 64'd2024, 7'h24, 7'h40, 7'h24, 7'h19, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hex_display_driver.md
HEX_DISPLAY_DRIVER -- requirements
Module: hex_display_driver

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: value  input  64  unsigned register value to display, sampled only on an accepted load.
REQ-004 SHALL have port: load  input  1  conversion request, accepted only while busy=0.
REQ-005 SHALL have port: busy  output  1  high while a conversion is in progress.
REQ-006 SHALL have port: done  output  1  one-cycle pulse when the HEX outputs update.
REQ-007 SHALL have port: ovf  output  1  high when the last accepted value exceeded 9999.
REQ-008 SHALL have ports: HEX3, HEX2, HEX1, HEX0  output  7 each  active-low segments {g,f,e,d,c,b,a}, HEX3 = thousands.

Function
REQ-009 SHALL implement states IDLE, SHIFT, DONE; IDLE -> SHIFT on load; SHIFT -> DONE after 14 shifts; DONE -> IDLE unconditionally.
REQ-010 On an accepted load at edge N, SHALL capture value[13:0] into the shift register, clear the BCD accumulator and shift counter, and set busy=1.
REQ-011 SHALL also set an overflow latch at edge N iff value > 9999, comparing all 64 bits unsigned.
REQ-012 At each edge N+1 .. N+14, SHALL perform one double-dabble step: add 3 to every BCD digit >= 5, then shift {bcd,bin} left by 1.
REQ-013 At edge N+15 (the DONE state), SHALL register HEX3..HEX0, set ovf from the latch, pulse done=1 for exactly one cycle, and clear busy.
REQ-014 Load-to-display latency SHALL be exactly 15 clocks, including for overflow values.
REQ-015 SHALL ignore load while busy=1, including the DONE cycle; a load held high SHALL start the next conversion at the edge after done.
REQ-016 HEX outputs and ovf SHALL hold their last values between conversions.
REQ-017 Digit encoding SHALL be 0=40h, 1=79h, 2=24h, 3=30h, 4=19h, 5=12h, 6=02h, 7=78h, 8=00h, 9=10h, blank=7Fh, dash=3Fh.
REQ-018 When ovf applies, all four displays SHALL show dash (3Fh).
REQ-019 Inputs value=0 and value=9999 SHALL NOT set ovf; value=10000 and value with only bit 63 set SHALL set ovf.

Reset
REQ-020 When rst=1 at an edge, SHALL enter IDLE with busy=0, done=0, ovf=0, and HEX3..HEX0=7Fh (blank), regardless of state.
REQ-021 A reset mid-conversion SHALL abort it without producing a done pulse; a load asserted together with rst SHALL be ignored.

Configuration
REQ-022 With macro HEX_LEADING_ZERO_BLANK_EN defined, leading zero digits of HEX3..HEX1 SHALL show blank (7Fh); HEX0 SHALL always show its digit.
REQ-023 Without HEX_LEADING_ZERO_BLANK_EN, all four digits SHALL always be shown, including leading zeros; ovf display is the same in both builds.

Verification
REQ-024 Reset, then no load -> HEX3..HEX0 = 7Fh, busy=0, done=0, ovf=0.
REQ-025 load=1 with value=1597 for one cycle -> busy high 15 cycles, done pulse at edge N+15, HEX = 79h,12h,10h,78h, ovf=0.
REQ-026 value=7 -> HEX = 40h,40h,40h,78h without the macro; 7Fh,7Fh,7Fh,78h with the macro.
REQ-027 value=10000, then value=64'h8000_0000_0000_0000 -> each gives all HEX = 3Fh and ovf=1; value=9999 -> HEX = 10h x4, ovf=0.
REQ-028 A second load at cycles N+5 and N+15 -> both ignored, one done pulse; load held high continuously -> done pulses every 16 cycles.
REQ-029 rst=1 at N+7 of a conversion -> no done pulse, outputs at reset values; next load converts correctly.
